tcam_match_pipe: RTL and testbench

TCAM_MATCH_PIPE -- requirements
Module: tcam_match_pipe

---
 rtl/tcam_match_pipe.sv | 134 +++++++++++++
 tb/tb_tcam_match_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tcam_match_pipe.sv
// -----------------------------------------------------------------------------
// tcam_match_pipe
//   Ternary CAM with a two-stage search pipeline.  Each of DEPTH entries holds
//   a key, a care mask (1 = compare, 0 = don't-care) and a valid bit.  A search
//   compares s_key against every entry in parallel; the per-entry match vector
//   is registered in stage 1, and stage 2 registers the final match vector,
//   hit flag and lowest matching index.  A full stage 2 that is not accepted
//   downstream stalls the whole pipe.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_addr       entry write strobe and index (out-of-range ignored)
//   wr_key/wr_mask      stored key and care mask
//   wr_valid            stored entry-valid bit (0 invalidates the entry)
//   s_key/s_valid       search request
//   s_ready             search accepted when s_valid && s_ready
//   m_match             per-entry match vector (bit i = entry i)
//   m_hit/m_index       any-match flag and lowest matching entry
//   m_valid/m_ready     result handshake
// -----------------------------------------------------------------------------
module tcam_match_pipe #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 16,
  localparam int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_key,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] s_key,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DEPTH-1:0]      m_match,
  output logic                  m_hit,
  output logic [IDX_WIDTH-1:0]  m_index,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam logic [IDX_WIDTH:0] DEPTH_LIM = (IDX_WIDTH + 1)'(DEPTH);

  // Lowest set bit of a match vector; 0 when the vector is empty.
  function automatic logic [IDX_WIDTH-1:0] lowest_idx(input logic [DEPTH-1:0] v);
    logic [IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) idx = i[IDX_WIDTH-1:0];
    end
    return idx;
  endfunction

  logic [DATA_WIDTH-1:0] key_q  [DEPTH];
  logic [DATA_WIDTH-1:0] mask_q [DEPTH];
  logic [DEPTH-1:0]      ent_vld;

  logic                  wr_ok;
  logic                  stall;
  logic [DEPTH-1:0]      cmp_p0;
  logic [DEPTH-1:0]      match_p1;
  logic                  vld_p1;
  logic [DEPTH-1:0]      match_p1_q;
  logic                  hit_p1;
  logic [IDX_WIDTH-1:0]  idx_p1;
  logic [DEPTH-1:0]      match_p2;
  logic                  hit_p2;
  logic [IDX_WIDTH-1:0]  idx_p2;
  logic                  vld_p2;

  // Addresses past the last entry only exist when DEPTH is not a power of two.
  assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_LIM);
  assign stall   = vld_p2 && !m_ready;
  assign s_ready = !stall;

  // Entry storage.  Key/mask need no reset: cleared valid bits mask them out.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      key_q[wr_addr]  <= wr_key;
      mask_q[wr_addr] <= wr_mask;
    end
  end

  // Stage 0: parallel compare against the contents before any same-cycle write.
  always_comb begin
    cmp_p0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmp_p0[i] = ent_vld[i] && (((s_key ^ key_q[i]) & mask_q[i]) == '0);
    end
  end

  // Stage 1: snapshot of the compare vector, frozen while stalled so later
  // writes cannot change a search already in flight.
  always_ff @(posedge clk) begin
    if (!stall) match_p1 <= cmp_p0;
  end

  // An empty stage 1 forwards an all-zero vector so idle outputs read as a miss.
  always_comb begin
    match_p1_q = match_p1 & {DEPTH{vld_p1}};
    hit_p1     = |match_p1_q;
    idx_p1     = lowest_idx(match_p1_q);
  end

  // Control state plus the stage-2 result registers, which are visible on the
  // ports and therefore cleared in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld  <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      match_p2 <= '0;
      hit_p2   <= 1'b0;
      idx_p2   <= '0;
    end else begin
      if (wr_ok) ent_vld[wr_addr] <= wr_valid;
      if (!stall) begin
        vld_p1   <= s_valid;
        // Stage 2: final match vector, hit and priority index.
        vld_p2   <= vld_p1;
        match_p2 <= match_p1_q;
        hit_p2   <= hit_p1;
        idx_p2   <= idx_p1;
      end
    end
  end

  assign m_valid = vld_p2;
  assign m_match = match_p2;
  assign m_hit   = hit_p2;
  assign m_index = idx_p2;

endmodule

// File: tb/tb_tcam_match_pipe.sv
module tb_tcam_match_pipe;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_key;
  logic [31:0] wr_mask;
  logic        wr_valid;
  logic [31:0] s_key;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_match;
  logic        m_hit;
  logic [3:0]  m_index;
  logic        m_valid;
  logic        m_ready;

  int n_chk = 0;
  int n_err = 0;

  tcam_match_pipe #(.DATA_WIDTH(32), .DEPTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_key   (wr_key),
    .wr_mask  (wr_mask),
    .wr_valid (wr_valid),
    .s_key    (s_key),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_match  (m_match),
    .m_hit    (m_hit),
    .m_index  (m_index),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] k, input logic [31:0] m,
                    input logic v);
    wr_en = 1'b1; wr_addr = a; wr_key = k; wr_mask = m; wr_valid = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [15:0] em, input logic eh,
                           input logic [3:0] ei);
    check({tag, "_vld"},   64'(m_valid), 64'(1'b1));
    check({tag, "_match"}, 64'(m_match), 64'(em));
    check({tag, "_hit"},   64'(m_hit),   64'(eh));
    check({tag, "_idx"},   64'(m_index), 64'(ei));
  endtask

  // Single isolated search: result visible after the second edge only.
  task automatic search_chk(input string tag, input logic [31:0] k, input logic [15:0] em,
                            input logic eh, input logic [3:0] ei);
    s_valid = 1'b1; s_key = k;
    step();
    s_valid = 1'b0;
    check({tag, "_lat1"}, 64'(m_valid), 64'(1'b0));
    step();
    check_res(tag, em, eh, ei);
    step();
    check({tag, "_drain"}, 64'(m_valid), 64'(1'b0));
  endtask

  logic [31:0] b_key   [3];
  logic [15:0] b_match [3];
  logic [3:0]  b_idx   [3];

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_key = '0; wr_mask = '0;
    wr_valid = 1'b0; s_key = '0; s_valid = 1'b0; m_ready = 1'b1;

    // Reset state
    step(); step();
    check("rst_mvalid", 64'(m_valid), 64'(1'b0));
    check("rst_match",  64'(m_match), 64'(16'h0));
    check("rst_hit",    64'(m_hit),   64'(1'b0));
    check("rst_idx",    64'(m_index), 64'(4'h0));
    check("rst_sready", 64'(s_ready), 64'(1'b1));
    rst_n = 1'b1;
    step();
    check("post_rst_sready", 64'(s_ready), 64'(1'b1));

    // Empty table misses
    search_chk("empty", 32'hDEADBEEF, 16'h0000, 1'b0, 4'd0);

    // Masked and all-don't-care entries
    wr(4'd3, 32'h0000_00AB, 32'h0000_00FF, 1'b1);
    wr(4'd7, 32'h0000_0000, 32'h0000_0000, 1'b1);
    wr(4'd5, 32'h0000_00F0, 32'h0000_00F0, 1'b1);
    search_chk("e3e7", 32'h1234_56AB, 16'h0088, 1'b1, 4'd3);
    search_chk("e7",   32'h1234_5600, 16'h0080, 1'b1, 4'd7);

    // Back-to-back searches, one result per cycle
    b_key[0] = 32'h0000_00AB; b_match[0] = 16'h0088; b_idx[0] = 4'd3;
    b_key[1] = 32'h0000_00F3; b_match[1] = 16'h00A0; b_idx[1] = 4'd5;
    b_key[2] = 32'h0000_0011; b_match[2] = 16'h0080; b_idx[2] = 4'd7;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        s_valid = 1'b1; s_key = b_key[c];
      end else begin
        s_valid = 1'b0;
      end
      step();
      if (c >= 1 && c <= 3) check_res($sformatf("b2b%0d", c - 1), b_match[c-1], 1'b1, b_idx[c-1]);
      if (c == 0 || c == 4) check($sformatf("b2b_idle%0d", c), 64'(m_valid), 64'(1'b0));
    end

    // Backpressure: A in stage 2, B in stage 1, C waiting at the input
    m_ready = 1'b0;
    s_valid = 1'b1; s_key = b_key[0];
    check("stall_sr0", 64'(s_ready), 64'(1'b1));
    step();
    s_key = b_key[1];
    check("stall_bubble_sr", 64'(s_ready), 64'(1'b1));
    step();
    s_key = b_key[2];
    check("stall_sr", 64'(s_ready), 64'(1'b0));
    check_res("stall_a", 16'h0088, 1'b1, 4'd3);
    for (int k = 0; k < 5; k++) begin
      // Invalidate entry 7 while B's vector (which includes entry 7) is parked.
      if (k == 0) begin
        wr_en = 1'b1; wr_addr = 4'd7; wr_key = '0; wr_mask = '0; wr_valid = 1'b0;
      end
      step();
      wr_en = 1'b0;
      check($sformatf("stall%0d_sr", k), 64'(s_ready), 64'(1'b0));
      check_res($sformatf("stall%0d_hold", k), 16'h0088, 1'b1, 4'd3);
    end
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    check_res("rel_b", 16'h00A0, 1'b1, 4'd5);
    step();
    check_res("rel_c", 16'h0000, 1'b0, 4'd0);
    step();
    check("rel_drain", 64'(m_valid), 64'(1'b0));

    // Invalidate entry 3 in the same cycle as a search that hits it
    wr_en = 1'b1; wr_addr = 4'd3; wr_key = 32'h0000_00AB; wr_mask = 32'h0000_00FF; wr_valid = 1'b0;
    s_valid = 1'b1; s_key = 32'h0000_00AB;
    step();
    wr_en = 1'b0;
    step();
    s_valid = 1'b0;
    check_res("wr_same", 16'h0008, 1'b1, 4'd3);
    step();
    check_res("wr_after", 16'h0000, 1'b0, 4'd0);
    step();

    // Reset with two searches in flight (entry 5 matches 0xF0)
    s_valid = 1'b1; s_key = 32'h0000_00F0;
    step();
    step();
    s_valid = 1'b0;
    check_res("pre_rst", 16'h0020, 1'b1, 4'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld",   64'(m_valid), 64'(1'b0));
    check("mid_rst_match", 64'(m_match), 64'(16'h0));
    check("mid_rst_sr",    64'(s_ready), 64'(1'b1));
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post_rst%0d_vld", k), 64'(m_valid), 64'(1'b0));
    end
    search_chk("all_inv", 32'h0000_00F0, 16'h0000, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
